// File: rtl/sprite_cmd_writer.sv
// sprite_cmd_writer: shadows child sprite attributes and replays them, then a buffer swap, on every frame_start.
// Define SPRITE_CMD_SKIP_HIDDEN_EN to send only the attribute word for hidden children.
module sprite_cmd_writer #(
  parameter logic [5:0] COMPONENT_ID = 6'b001010,
  parameter int         CHILD_LIMIT  = 2,
  parameter int         PATTERN_NUM  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        host_write,
  input  logic [4:0]  host_child,
  input  logic [2:0]  host_type,
  input  logic [12:0] host_data,
  input  logic        frame_start,
  output logic [31:0] writedata,
  output logic        cmd_valid,
  output logic        busy,
  output logic        host_err,
  output logic        overrun
);
  localparam int         CW   = CHILD_LIMIT > 1 ? $clog2(CHILD_LIMIT) : 1;
  localparam int         CN   = 1 << CW;
  localparam logic [4:0] LAST = 5'(CHILD_LIMIT - 1);

  typedef enum logic [1:0] {IDLE, EMIT, SWAP} state_e;

  state_e      state_q;
  logic [4:0]  child_q;
  logic [1:0]  field_q;
  logic        back_buf_q;
  logic [31:0] writedata_q, writedata_d;
  logic        cmd_valid_q, busy_q, host_err_q, overrun_q;

  logic       vis_q   [CN];
  logic       flip_q  [CN];
  logic [4:0] pat_q   [CN];
  logic [9:0] x_q     [CN];
  logic [9:0] y_q     [CN];
  logic [9:0] shift_q [CN];

  logic [CW-1:0] rd_idx, wr_idx;
  logic          type_ok, wr_ok, skip, child_done, unused;
  logic [9:0]    coord;
  logic [12:0]   msg;
  logic [31:0]   upd_word, swap_word;

  assign rd_idx  = child_q[CW-1:0];
  assign wr_idx  = host_child[CW-1:0];
  assign unused  = host_data[10];
  assign type_ok = host_type != 3'd0 && host_type <= 3'd4;
  assign wr_ok   = 32'(host_child) < CHILD_LIMIT && type_ok &&
                   !(host_type == 3'd1 && 32'(host_data[4:0]) >= PATTERN_NUM);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < CN; i++) begin
        vis_q[i]   <= 1'b0;
        flip_q[i]  <= 1'b0;
        pat_q[i]   <= '0;
        x_q[i]     <= '0;
        y_q[i]     <= '0;
        shift_q[i] <= '0;
      end
      host_err_q <= 1'b0;
    end else begin
      host_err_q <= host_write && !wr_ok;
      if (host_write && wr_ok) begin
        if (host_type == 3'd1) begin
          vis_q[wr_idx]  <= host_data[12];
          flip_q[wr_idx] <= host_data[11];
          pat_q[wr_idx]  <= host_data[4:0];
        end
        if (host_type == 3'd2) x_q[wr_idx] <= host_data[9:0];
        if (host_type == 3'd3) y_q[wr_idx] <= host_data[9:0];
        if (host_type == 3'd4) shift_q[wr_idx] <= host_data[9:0];
      end
    end
  end

`ifdef SPRITE_CMD_SKIP_HIDDEN_EN
  // visibility is sampled while the child's attribute word is being emitted
  assign skip = field_q == 2'd0 && !vis_q[rd_idx];
`else
  assign skip = 1'b0;
`endif

  assign child_done  = field_q == 2'd3 || skip;
  assign coord       = field_q == 2'd1 ? x_q[rd_idx] : field_q == 2'd2 ? y_q[rd_idx] : shift_q[rd_idx];
  assign msg         = field_q == 2'd0 ? {vis_q[rd_idx], flip_q[rd_idx], 6'b0, pat_q[rd_idx]} : {3'b0, coord};
  assign upd_word    = {COMPONENT_ID, child_q, 4'b0001, {1'b0, field_q} + 3'd1, back_buf_q, msg};
  assign swap_word   = {COMPONENT_ID, 5'd0, 4'b1111, 3'b000, back_buf_q, 13'd0};
  assign writedata_d = state_q == EMIT ? upd_word : state_q == SWAP ? swap_word : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      child_q     <= '0;
      field_q     <= '0;
      back_buf_q  <= 1'b1;
      writedata_q <= '0;
      cmd_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      writedata_q <= writedata_d;
      cmd_valid_q <= state_q != IDLE;
      busy_q      <= state_q != IDLE;
      overrun_q   <= overrun_q || (frame_start && state_q != IDLE);
      if (state_q == IDLE) begin
        if (frame_start) begin
          state_q <= EMIT;
          child_q <= '0;
          field_q <= '0;
        end
      end else if (state_q == EMIT) begin
        if (!child_done) field_q <= field_q + 2'd1;
        else begin
          field_q <= '0;
          if (child_q == LAST) state_q <= SWAP;
          else child_q <= child_q + 5'd1;
        end
      end else begin
        back_buf_q <= !back_buf_q;
        state_q    <= IDLE;
      end
    end
  end

  assign writedata = writedata_q;
  assign cmd_valid = cmd_valid_q;
  assign busy      = busy_q;
  assign host_err  = host_err_q;
  assign overrun   = overrun_q;
endmodule

// File: tb/tb_sprite_cmd_writer.sv
// tb_sprite_cmd_writer: scoreboard bench; a frame-level model queues expected words, a monitor pops them.
module tb_sprite_cmd_writer;
  localparam int          CL = 2;
  localparam int          PN = 2;
  localparam logic [31:0] ID = 32'h0A;

  logic        clk = 0, reset = 1, host_write = 0, frame_start = 0;
  logic [4:0]  host_child = 0;
  logic [2:0]  host_type = 0;
  logic [12:0] host_data = 0;
  logic [31:0] writedata;
  logic        cmd_valid, busy, host_err, overrun;

  int          checks = 0, errors = 0, exp_err = 0, err_pulses = 0;
  logic [31:0] exp_q[$];
  bit          m_vis[CL], m_flip[CL];
  int          m_pat[CL], m_x[CL], m_y[CL], m_sh[CL];
  int          m_bb = 1;

  always #5 clk = ~clk;

  sprite_cmd_writer dut (
    .clk(clk), .reset(reset), .host_write(host_write), .host_child(host_child),
    .host_type(host_type), .host_data(host_data), .frame_start(frame_start),
    .writedata(writedata), .cmd_valid(cmd_valid), .busy(busy),
    .host_err(host_err), .overrun(overrun)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word(int c, int t, int msg);
    return (ID << 26) | (32'(c) << 21) | (32'd1 << 17) | (32'(t) << 14) | (32'(m_bb) << 13) | 32'(msg);
  endfunction

  function automatic void push_frame();
    for (int c = 0; c < CL; c++) begin
      exp_q.push_back(word(c, 1, (int'(m_vis[c]) << 12) | (int'(m_flip[c]) << 11) | m_pat[c]));
`ifdef SPRITE_CMD_SKIP_HIDDEN_EN
      if (!m_vis[c]) continue;
`endif
      exp_q.push_back(word(c, 2, m_x[c]));
      exp_q.push_back(word(c, 3, m_y[c]));
      exp_q.push_back(word(c, 4, m_sh[c]));
    end
    exp_q.push_back((ID << 26) | (32'hF << 17) | (32'(m_bb) << 13));
    m_bb ^= 1;
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < CL; c++) begin
      m_vis[c] = 0; m_flip[c] = 0; m_pat[c] = 0; m_x[c] = 0; m_y[c] = 0; m_sh[c] = 0;
    end
    m_bb = 1;
    exp_q.delete();
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input bit hw, input int c, input int t, input int d, input bit fs, input bit acc);
    bit ok;
    step();
    host_write = hw; host_child = 5'(c); host_type = 3'(t); host_data = 13'(d); frame_start = fs;
    ok = c < CL && t >= 1 && t <= 4 && !(t == 1 && (d & 31) >= PN);
    if (hw && ok) begin
      if (t == 1) begin m_vis[c] = d[12]; m_flip[c] = d[11]; m_pat[c] = d & 31; end
      if (t == 2) m_x[c] = d & 1023;
      if (t == 3) m_y[c] = d & 1023;
      if (t == 4) m_sh[c] = d & 1023;
    end
    if (hw && !ok) exp_err++;
    if (fs && acc) push_frame();
    step();
    host_write = 0; frame_start = 0;
    if (hw) check("host_err", 32'(host_err), 32'(!ok));
  endtask

  task automatic frame();
    drive(0, 0, 0, 0, 1, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 60) begin
      step();
      n++;
    end
    check("replay_done", 32'(exp_q.size()), 0);
  endtask

  always begin
    @(negedge clk);
    #2;
    if (reset) begin
      if (host_err) err_pulses++;
      check("busy_vs_valid", {30'b0, busy, cmd_valid}, {30'b0, cmd_valid, writedata != 0});
      if (cmd_valid) begin
        if (exp_q.size() == 0) check("unexpected_word", writedata, 0);
        else check("word", writedata, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #1 reset = 0;
    repeat (3) step();
    check("rst_writedata", writedata, 0);
    check("rst_cmd_valid", 32'(cmd_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_host_err", 32'(host_err), 0);
    check("rst_overrun", 32'(overrun), 0);
    model_reset();
    reset = 1;
    step();

    drive(1, 1, 2, 100, 0, 0);
    frame();
    repeat (6) step();
    check("x_word_c6", writedata, 32'h2822A064);
    repeat (3) step();
    check("swap_c9", writedata, 32'h281E2000);
    step();
    check("idle_c10", writedata, 0);
    check("busy_c10", 32'(busy), 0);
    frame();
    repeat (9) step();
    check("swap_buf0", writedata, 32'h281E0000);
    wait_idle();

    drive(1, 2, 1, 0, 0, 0);
    drive(1, 0, 1, 3, 0, 0);
    drive(1, 0, 5, 7, 0, 0);
    drive(1, 0, 1, 13'h1801, 0, 0);
    frame();
    wait_idle();

    drive(1, 1, 3, 513, 1, 1);
    wait_idle();

    frame();
    repeat (8) step();
    frame();
    wait_idle();
    check("overrun_b2b", 32'(overrun), 0);

    frame();
    repeat (3) step();
    drive(0, 0, 0, 0, 1, 0);
    wait_idle();
    check("overrun_set", 32'(overrun), 1);
    frame();
    wait_idle();
    check("overrun_sticky", 32'(overrun), 1);

    frame();
    repeat (5) step();
    reset = 0;
    model_reset();
    #1;
    check("midrst_writedata", writedata, 0);
    check("midrst_cmd_valid", 32'(cmd_valid), 0);
    check("midrst_overrun", 32'(overrun), 0);
    step();
    reset = 1;
    frame();
    repeat (9) step();
    check("swap_after_rst", writedata, 32'h281E2000);
    wait_idle();

    repeat (40) begin
      int n, t;
      n = $urandom_range(0, 3);
      for (int i = 0; i < n; i++) begin
        t = $urandom_range(0, 7);
        drive(1, $urandom_range(0, 2), t, int'(($urandom & 32'h1FE0) | $urandom_range(0, 3)), 0, 0);
      end
      t = $urandom_range(1, 4);
      drive($urandom_range(0, 1) == 1, $urandom_range(0, 1), t,
            int'(($urandom & 32'h1FE0) | $urandom_range(0, 3)), 1, 1);
      wait_idle();
    end

    step();
    check("queue_empty", 32'(exp_q.size()), 0);
    check("err_pulses", 32'(err_pulses), 32'(exp_err));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sprite_cmd_writer.md
# sprite_cmd_writer

Command-stream generator that drives the 32-bit `writedata` word consumed by a double-buffered sprite display component. It keeps a shadow copy of every child sprite's attributes, written by game/host logic. On each frame-start pulse it replays all children into the display's back buffer, then issues the buffer-swap word. It sits between the host register file and one display component instance, one writer per component.

## Interface
Parameters:
- `COMPONENT_ID`, default 6'b001010: value placed in `writedata[31:26]` of every update word.
- `CHILD_LIMIT`, default 2: number of child sprites held and replayed, 1..32.
- `PATTERN_NUM`, default 2: pattern codes at or above this value are rejected.

Ports:
- `clk`, in, 1: single clock.
- `reset`, in, 1: asynchronous, active-low reset.
- `host_write`, in, 1: one-cycle shadow write strobe.
- `host_child`, in, 5: target child index.
- `host_type`, in, 3: field selector.
  - 001: attribute, meaning visible = data[12], flip = data[11], pattern = data[4:0].
  - 010: x, data[9:0].
  - 011: y, data[9:0].
  - 100: shift, data[9:0].
- `host_data`, in, 13: field payload.
- `frame_start`, in, 1: one-cycle vblank pulse that starts a replay.
- `writedata`, out, 32: command word to the display component.
- `cmd_valid`, out, 1: high when `writedata` carries a non-idle word.
- `busy`, out, 1: replay or swap in progress.
- `host_err`, out, 1: one-cycle pulse flagging a rejected host write.
- `overrun`, out, 1: sticky flag; set when `frame_start` arrives while `busy`.

## Operation
- **Word format:** [31:26] component, [25:21] child, [20:17] info, [16:14] type, [13] buffer_select, [12:0] msg.
  - Idle word is 32'h0 (info 0000).
  - Update words use info 0001.
  - Swap word uses info 1111.
- **Shadow per child:** visible, flip, pattern[4:0], x[9:0], y[9:0], shift[9:0]. All zero at reset.
- **Host writes:**
  - The shadow updates on the cycle `host_write` is high.
  - A write is rejected (shadow unchanged, `host_err` pulses the next cycle) when any of these holds:
    - `host_child` ≥ CHILD_LIMIT.
    - `host_type` is not in {001, 010, 011, 100}.
    - The type is 001 and data[4:0] ≥ PATTERN_NUM.
  - Host writes are accepted at any time. A word emitted in cycle t reflects every write accepted before t.
- **`back_buf` register:** reset value 1, matching the display's front buffer of 0 at reset.
- **FSM states:**
  - IDLE: `frame_start` → EMIT with child = 0 and field = attr.
  - EMIT: emits one word per cycle in order child 0 {attr, x, y, shift}, child 1 {...}, and so on. All words carry buffer_select = `back_buf`. After the last field of child CHILD_LIMIT-1 → SWAP.
  - SWAP: emits {COMPONENT_ID, 5'd0, 4'b1111, 3'b000, back_buf, 13'd0}, toggles `back_buf`, → IDLE.
- **Attribute word msg:** {visible, flip, 6'b0, pattern}. Coordinate and shift words carry msg = {3'b0, value}.
- **Why every frame replays everything:** the display clears visibility in the new back buffer on every swap, so the full shadow must be replayed each frame.
- **`frame_start` while busy:** ignored; `overrun` is set and stays set until reset.
- **Reset mid-replay:** the FSM returns to IDLE, `writedata` goes to 0, and `back_buf` returns to 1.

## Timing
- **Reset values:** `writedata` = 0, `cmd_valid` = 0, `busy` = 0, `host_err` = 0, `overrun` = 0.
- **Registered outputs:** all outputs are registered. `writedata` returns to 0 on the cycle after the swap word.
- **Replay latency:** with `frame_start` sampled at edge 0:
  - First update word appears after edge 1.
  - Update words occupy 4·CHILD_LIMIT consecutive cycles.
  - Swap word appears in cycle 4·CHILD_LIMIT+1.
  - Default configuration: words in cycles 1..8, swap in cycle 9.
- **`busy`:** high from cycle 1 through the swap cycle, inclusive.
- **Back-to-back frames:** a `frame_start` on the cycle after the swap word is accepted.
- **Coincident events:** `host_write` and `frame_start` in the same cycle means the write is visible in the replay.

## Configuration
- **`SPRITE_CMD_SKIP_HIDDEN_EN` defined:** a child whose shadow visible = 0 emits only its attribute word. Its x, y and shift words are skipped with no gap cycles, so the replay length is variable. The visible flag is sampled when the FSM reaches that child's attribute word.
- **Undefined:** every child always emits all four words.

## Test plan
- **Reset values:** assert `reset` = 0 → `writedata` = 0, `cmd_valid` = 0, `overrun` = 0. After release, the first swap word is 32'h281E2000.
- **Single x write and replay:** host writes child 1, type 010, data 100, then pulse `frame_start`.
  - Cycle 6 carries 32'h2822A064.
  - Cycle 9 carries the swap word 32'h281E2000.
  - The next frame's swap word is 32'h281E0000.
- **Invalid host writes:** child 2, type 001 with pattern 3, and type 101 each pulse `host_err` exactly once and leave the shadow unchanged on the next replay.
- **Overrun:** pulse `frame_start` at cycle 4 of a replay → `overrun` = 1 and the word sequence is unchanged. The flag persists until reset.
- **Reset mid-replay:** assert `reset` at cycle 5 → `writedata` = 0 immediately. After release and a `frame_start`, the swap word again uses buffer 1.
- **`SPRITE_CMD_SKIP_HIDDEN_EN` defined:** child 0 hidden and child 1 visible → 5 update words then the swap in cycle 6. With the macro undefined, the swap is in cycle 9.
